// File: rtl/norm_share_ctrl_if.sv
// norm_share_ctrl_if -- signal bundle around the shared-normaliser controller.
//
// Groups the three handshakes the controller takes part in:
//   requesters : req / reqData in, gnt out (gnt is a 1-cycle capture pulse)
//   normaliser : norm_start / norm_D out, norm_done / norm_F / norm_P in
//   consumer   : out_valid / out_F / out_P / out_id / out_err out, out_ready in
//
// Handshake rules: out_valid, once high, stays high with out_* frozen until
// the cycle where out_ready is also high; that cycle is the transfer.
// norm_start is a single-cycle pulse; norm_D is held from that pulse until
// norm_done (or the timeout) ends the wait. norm_done is only looked at while
// waiting, out_ready only while a result is held.
//
// Modports: master = controller side, slave = environment side.
interface norm_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]   gnt;
  logic                 norm_start;
  logic [3:0]           norm_D;
  logic                 norm_done;
  logic [3:0]           norm_F;
  logic [1:0]           norm_P;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_F;
  logic [1:0]           out_P;
  logic [ID_W-1:0]      out_id;
  logic                 out_err;

  modport master (
    input  req, reqData, norm_done, norm_F, norm_P, out_ready,
    output gnt, norm_start, norm_D, out_valid, out_F, out_P, out_id, out_err
  );

  modport slave (
    output req, reqData, norm_done, norm_F, norm_P, out_ready,
    input  gnt, norm_start, norm_D, out_valid, out_F, out_P, out_id, out_err
  );
endinterface

// File: rtl/norm_share_ctrl.sv
// norm_share_ctrl -- shares one 4-bit normaliser among NUM_REQ requesters.
//
// One word is accepted per transaction from the arbitration winner, sent to
// the normaliser (zero words skip it), and the result is returned tagged with
// the requester id. A hung normaliser is aborted after TIMEOUT wait cycles and
// reported with out_err=1, F=0, P=0.
//
// Ports:
//   sysClk      clock, rising edge
//   sysRst      asynchronous reset, active-high
//   bus         norm_share_ctrl_if.master (requester, normaliser, result)
//   o_dbg_state current FSM state (IDLE=0, ISSUE=1, WAIT=2, HOLD=3)
//
// Configuration macro: NORM_SHARE_PRIO_EN -- when defined, the lowest
// requesting index always wins and no round-robin pointer exists; otherwise
// round-robin arbitration starting at the pointer.
module norm_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 5
) (
  input  logic                sysClk,
  input  logic                sysRst,
  norm_share_ctrl_if.master   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_norm_start;
  logic [3:0]         r_norm_D;
  logic [3:0]         r_word;
  logic [ID_W-1:0]    r_id;
  logic [3:0]         r_out_F;
  logic [1:0]         r_out_P;
  logic [ID_W-1:0]    r_out_id;
  logic               r_out_err;
  logic [TMR_W-1:0]   r_timer;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [3:0]         w_word;
  logic [NUM_REQ-1:0] w_gnt;
  int                 w_idx;

`ifndef NORM_SHARE_PRIO_EN
  logic [ID_W-1:0]    r_rr;
  logic [ID_W-1:0]    w_rr_next;
`endif

  // Arbitration: scan NUM_REQ slots from the start point (pointer or 0),
  // first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_word  = '0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef NORM_SHARE_PRIO_EN
      w_idx = k;
`else
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
`endif
      if (!w_found && bus.req[w_idx]) begin
        w_found       = 1'b1;
        w_win         = ID_W'(w_idx);
        w_word        = bus.reqData[4*w_idx +: 4];
        w_gnt[w_idx]  = 1'b1;
      end
    end
  end

`ifndef NORM_SHARE_PRIO_EN
  assign w_rr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif

  // Next-state logic. The zero-word decision is made in ISSUE so a zero word
  // reaches HOLD on the same step where a real word would pulse norm_start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = (r_word == 4'd0) ? S_HOLD : S_WAIT;
      S_WAIT:  if (bus.norm_done || (r_timer == TMR_LAST)) w_next = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath registers; gnt and norm_start default low so each is a pulse.
  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      r_gnt        <= '0;
      r_norm_start <= 1'b0;
      r_norm_D     <= '0;
      r_word       <= '0;
      r_id         <= '0;
      r_out_F      <= '0;
      r_out_P      <= '0;
      r_out_id     <= '0;
      r_out_err    <= 1'b0;
      r_timer      <= '0;
`ifndef NORM_SHARE_PRIO_EN
      r_rr         <= '0;
`endif
    end else begin
      r_gnt        <= '0;
      r_norm_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt  <= w_gnt;
            r_word <= w_word;
            r_id   <= w_win;
`ifndef NORM_SHARE_PRIO_EN
            r_rr   <= w_rr_next;
`endif
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          if (r_word != 4'd0) begin
            r_norm_start <= 1'b1;
            r_norm_D     <= r_word;
          end else begin
            r_out_F   <= '0;
            r_out_P   <= '0;
            r_out_id  <= r_id;
            r_out_err <= 1'b0;
          end
        end
        S_WAIT: begin
          // done in the last timeout cycle still counts as a good result
          if (bus.norm_done) begin
            r_out_F   <= bus.norm_F;
            r_out_P   <= bus.norm_P;
            r_out_id  <= r_id;
            r_out_err <= 1'b0;
          end else if (r_timer == TMR_LAST) begin
            r_out_F   <= '0;
            r_out_P   <= '0;
            r_out_id  <= r_id;
            r_out_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.norm_start = r_norm_start;
  assign bus.norm_D     = r_norm_D;
  assign bus.out_valid  = (r_state == S_HOLD);
  assign bus.out_F      = r_out_F;
  assign bus.out_P      = r_out_P;
  assign bus.out_id     = r_out_id;
  assign bus.out_err    = r_out_err;
  assign o_dbg_state    = r_state;

endmodule
